uart_config_handshake: RTL

- Sequential configuration-protocol engine for the UART main controller, parametrised in packet width, field-ID width and option width.
- Sits between the RX FIFO and the TX FIFO. Detects a SYN byte from the host and accepts a sequence of configuration packets into a shadow register file.
- Acknowledges every packet and commits all fields atomically on the END command.
- Rejects malformed packets and aborts on an inactivity timeout.

---
 rtl/uart_config_handshake_pkg.sv | 20 ++
 rtl/uart_config_handshake_cfg_timeout_counter.sv | 25 ++
 rtl/uart_config_handshake.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_config_handshake_pkg.sv
// Shared constants, state encoding and packet helper for the UART configuration handshake.
package uart_config_handshake_pkg;

  localparam logic [7:0] ACK_PKT  = 8'hFF;
  localparam logic [7:0] NACK_PKT = 8'h00;
  localparam logic [7:0] SYN_PKT  = 8'h16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CFG_WAIT = 2'd1,
    SEND     = 2'd2
  } cfg_state_t;

  // Callers zero-extend id/option; the result is truncated to DATA_W at the use site.
  function automatic logic [31:0] make_pkt(input logic [31:0] id, input logic [31:0] opt,
                                           input int id_w);
    return (opt << id_w) | id;
  endfunction

endpackage

// File: rtl/uart_config_handshake_cfg_timeout_counter.sv
// Inactivity counter: counts enabled cycles without a clear and flags the final cycle.
module cfg_timeout_counter #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  // A clear in the last cycle (byte arrival) suppresses expiry.
  assign expired = enable & ~clear & (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         cnt <= '0;
    else if (!enable || clear || expired) cnt <= '0;
    else                                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_config_handshake.sv
// Config-protocol engine: SYN detect, shadowed field writes, atomic commit on END, ACK/NACK reply.
module uart_config_handshake
  import uart_config_handshake_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ID_W        = 2,
  parameter int OPT_W       = 2,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter logic [(2**ID_W-1)*OPT_W-1:0] CFG_RST = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           cfg_en_i,
  input  logic [DATA_W-1:0]              rx_data_i,
  input  logic                           rx_valid_i,
  output logic                           rx_ready_o,
  output logic [DATA_W-1:0]              tx_data_o,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic [(2**ID_W-1)*OPT_W-1:0]   cfg_o,
  output logic                           cfg_update_o,
  output logic                           cfg_busy_o,
  output logic                           error_o,
  output logic                           timeout_o
);

  localparam int CFG_W = (2**ID_W - 1) * OPT_W;

  cfg_state_t          state, state_nxt, ret, ret_nxt;
  logic [CFG_W-1:0]    shadow;
  logic [DATA_W-1:0]   tx_data_nxt;
  logic                tx_valid_nxt, rdy_nxt, busy_nxt, err_nxt, to_nxt, upd_nxt;
  logic                load_shadow, wr_field, commit;
  logic                xfer, expired, malformed, is_end;
  logic [ID_W-1:0]     id;
  logic [OPT_W-1:0]    opt;

  assign xfer      = rx_valid_i & rx_ready_o;
  assign id        = rx_data_i[ID_W-1:0];
  assign opt       = rx_data_i[ID_W+OPT_W-1:ID_W];
  assign is_end    = &id;
  // Shift rather than slice so DATA_W == ID_W+OPT_W (no spare bits) still elaborates.
  assign malformed = |(rx_data_i >> (ID_W + OPT_W));

  cfg_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .enable  (state == CFG_WAIT),
    .clear   (xfer),
    .expired (expired)
  );

  always_comb begin
    state_nxt    = state;
    ret_nxt      = ret;
    tx_valid_nxt = tx_valid_o;
    tx_data_nxt  = tx_data_o;
    err_nxt      = 1'b0;
    to_nxt       = 1'b0;
    upd_nxt      = 1'b0;
    load_shadow  = 1'b0;
    wr_field     = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && rx_data_i == DATA_W'(SYN_PKT)) begin
          state_nxt    = SEND;
          ret_nxt      = CFG_WAIT;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = DATA_W'(ACK_PKT);
          load_shadow  = 1'b1;
        end
      end
      CFG_WAIT: begin
        if (xfer) begin
          state_nxt    = SEND;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = DATA_W'(ACK_PKT);
          if (malformed) begin
            tx_data_nxt = DATA_W'(NACK_PKT);
            ret_nxt     = IDLE;
            err_nxt     = 1'b1;
            load_shadow = 1'b1;
          end else if (is_end) begin
            ret_nxt = IDLE;
            commit  = 1'b1;
            upd_nxt = 1'b1;
          end else begin
            ret_nxt  = CFG_WAIT;
            wr_field = 1'b1;
          end
        end else if (expired) begin
          state_nxt   = IDLE;
          to_nxt      = 1'b1;
          load_shadow = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = ret;
        end
      end
      default: state_nxt = IDLE;
    endcase
    rdy_nxt  = (state_nxt == CFG_WAIT) | ((state_nxt == IDLE) & cfg_en_i);
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      ret          <= IDLE;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= '0;
      rx_ready_o   <= 1'b0;
      cfg_busy_o   <= 1'b0;
      error_o      <= 1'b0;
      timeout_o    <= 1'b0;
      cfg_update_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      ret          <= ret_nxt;
      tx_valid_o   <= tx_valid_nxt;
      tx_data_o    <= tx_data_nxt;
      rx_ready_o   <= rdy_nxt;
      cfg_busy_o   <= busy_nxt;
      error_o      <= err_nxt;
      timeout_o    <= to_nxt;
      cfg_update_o <= upd_nxt;
    end
  end

  // Shadow reloads from the committed config on SYN and on any abort.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow <= CFG_RST;
      cfg_o  <= CFG_RST;
    end else begin
      if (load_shadow)   shadow <= cfg_o;
      else if (wr_field) shadow[int'(id)*OPT_W +: OPT_W] <= opt;
      if (commit)        cfg_o <= shadow;
    end
  end

endmodule
